// File: rtl/booth_div8_core_seq_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The issuing controller holds the master end; the divider core holds the slave end.
interface booth_div8_core_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [1:0]       sign_mode;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor, sign_mode,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, sign_mode,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/booth_div8_core_seq.sv
// Fixed-latency radix-2 restoring divider (WIDTH+2 clocks), truncating quotient,
// remainder signed like the dividend, per-operand signedness and divide-by-zero flag.
module booth_div8_core_seq #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_div8_core_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [1:0]       mode_q, mode_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             zero_q, zero_d;
  // Magnitudes always fit WIDTH unsigned bits (largest signed one is 2^(WIDTH-1)).
  // a_mag doubles as the quotient shift register: quotient bits enter at the LSB.
  logic [WIDTH-1:0] a_mag_q, a_mag_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic             trial_ge;

  // Restoring step: shifted partial remainder is WIDTH+1 bits; a kept value is
  // always below |b| and so fits back into WIDTH bits.
  assign r_shift  = {rem_q, a_mag_q[WIDTH-1]};
  assign trial_ge = (r_shift >= {1'b0, b_mag_q});

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    mode_d      = mode_q;
    a_neg_d     = a_neg_q;
    b_neg_d     = b_neg_q;
    zero_d      = zero_q;
    a_mag_d     = a_mag_q;
    b_mag_d     = b_mag_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          mode_d  = bus.sign_mode;
          state_d = PREP;
        end
      end
      PREP: begin
        a_neg_d = mode_q[1] & dvd_q[WIDTH-1];
        b_neg_d = mode_q[0] & dvs_q[WIDTH-1];
        a_mag_d = a_neg_d ? -dvd_q : dvd_q;
        b_mag_d = b_neg_d ? -dvs_q : dvs_q;
        zero_d  = (dvs_q == '0);
        rem_d   = '0;
        cnt_d   = CW'(WIDTH);
        state_d = ITER;
      end
      ITER: begin
        rem_d   = trial_ge ? WIDTH'(r_shift - {1'b0, b_mag_q}) : WIDTH'(r_shift);
        a_mag_d = {a_mag_q[WIDTH-2:0], trial_ge};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
        end else begin
          quotient_d  = (a_neg_q ^ b_neg_q) ? -a_mag_q : a_mag_q;
          remainder_d = a_neg_q ? -rem_q : rem_q;
        end
        dbz_d   = zero_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath is a handful of flops, not a memory, so all of it takes a reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      mode_q      <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      mode_q      <= mode_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      zero_q      <= zero_d;
      a_mag_q     <= a_mag_d;
      b_mag_q     <= b_mag_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_booth_div8_core_seq.sv
// Directed bench for booth_div8_core_seq: hand-computed quotient/remainder vectors,
// latency and busy-window checks, ignored start, divide-by-zero and mid-operation reset.
module tb_booth_div8_core_seq;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  booth_div8_core_seq_if #(.WIDTH(8)) bus ();

  booth_div8_core_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one division and follow it to done; optionally pulse start with other
  // operands while busy, which must be ignored.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] m, input logic [7:0] exp_q, input logic [7:0] exp_r,
                       input logic exp_z, input bit glitch);
    int  lat;
    int  busy_cnt;
    bit  seen;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.sign_mode = m;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.dividend  = 8'h3C;
    bus.divisor   = 8'h11;
    bus.sign_mode = ~m;
    check({tag, " done_low_after_start"}, {31'd0, bus.done}, 32'd0);
    lat = 0; busy_cnt = 0; seen = 1'b0;
    for (int i = 0; i <= 20 && !seen; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        lat  = i;
      end else begin
        if (bus.busy) busy_cnt++;
        if (glitch && i == 3) begin
          bus.start    = 1'b1;
          bus.dividend = 8'd9;
          bus.divisor  = 8'd3;
        end
        if (glitch && i == 4) bus.start = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    check({tag, " done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      check({tag, " latency"}, lat, 10);
      check({tag, " busy_cycles"}, busy_cnt, 10);
      check({tag, " busy_low_at_done"}, {31'd0, bus.busy}, 32'd0);
      check({tag, " quotient"}, {24'd0, bus.quotient}, {24'd0, exp_q});
      check({tag, " remainder"}, {24'd0, bus.remainder}, {24'd0, exp_r});
      check({tag, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, exp_z});
    end
  endtask

  initial begin
    int done_cnt;
    bus.start     = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.sign_mode = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst quotient", {24'd0, bus.quotient}, 32'd0);
    check("rst remainder", {24'd0, bus.remainder}, 32'd0);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst done", {31'd0, bus.done}, 32'd0);
    check("rst dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("u100/7",    8'd100, 8'd7,  2'b00, 8'd14, 8'd2,  1'b0, 1'b0);
    do_op("s-100/7",   8'h9C,  8'h07, 2'b11, 8'hF2, 8'hFE, 1'b0, 1'b0);
    do_op("s100/-7",   8'h64,  8'hF9, 2'b11, 8'hF2, 8'h02, 1'b0, 1'b0);
    do_op("m200/-3",   8'hC8,  8'hFD, 2'b01, 8'hBE, 8'h02, 1'b0, 1'b0);
    do_op("dbz11",     8'h55,  8'h00, 2'b11, 8'hFF, 8'h55, 1'b1, 1'b0);
    do_op("after_dbz", 8'd9,   8'd3,  2'b00, 8'd3,  8'd0,  1'b0, 1'b0);
    do_op("dbz00",     8'h55,  8'h00, 2'b00, 8'hFF, 8'h55, 1'b1, 1'b0);
    do_op("s80/-1",    8'h80,  8'hFF, 2'b11, 8'h80, 8'h00, 1'b0, 1'b0);
    do_op("uFF/1",     8'hFF,  8'h01, 2'b00, 8'hFF, 8'h00, 1'b0, 1'b0);
    do_op("glitch",    8'd100, 8'd7,  2'b00, 8'd14, 8'd2,  1'b0, 1'b1);

    // Abort mid-ITER with reset; no done may follow.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.dividend  = 8'd200;
    bus.divisor   = 8'd9;
    bus.sign_mode = 2'b00;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid busy_before_rst", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid quotient", {24'd0, bus.quotient}, 32'd0);
    check("mid remainder", {24'd0, bus.remainder}, 32'd0);
    check("mid busy", {31'd0, bus.busy}, 32'd0);
    check("mid done", {31'd0, bus.done}, 32'd0);
    check("mid dbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_cnt++;
    end
    check("mid no_done", done_cnt, 0);
    do_op("post_rst", 8'd9, 8'd3, 2'b00, 8'd3, 8'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
